// File: rtl/audio_i2s_rx_if.sv
// audio_i2s_rx_if: codec serial pins plus stereo-pair valid/ready handshake of the I2S receiver.
interface audio_i2s_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  AUD_BCLK;
    logic                  AUD_ADCLRCK;
    logic                  AUD_ADCDAT;
    logic [DATA_WIDTH-1:0] LEFT_DATA;
    logic [DATA_WIDTH-1:0] RIGHT_DATA;
    logic                  SAMPLE_VALID;
    logic                  SAMPLE_READY;
    logic                  OVERRUN;

    modport master (
        output AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT, SAMPLE_READY,
        input  LEFT_DATA, RIGHT_DATA, SAMPLE_VALID, OVERRUN
    );

    modport slave (
        input  AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT, SAMPLE_READY,
        output LEFT_DATA, RIGHT_DATA, SAMPLE_VALID, OVERRUN
    );
endinterface

// File: rtl/audio_i2s_rx.sv
// audio_i2s_rx: I2S ADC receiver; resynchronizes the codec pins and delivers left/right pairs with valid/ready.
module audio_i2s_rx #(
    parameter int DATA_WIDTH = 16
) (
    input logic           CLOCK,
    input logic           RESET,
    audio_i2s_rx_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;

    state_t                state;
    logic [1:0]            bclk_s, lrck_s, dat_s;
    logic                  bclk_d, lrck_d, rise, lr_tr, lr_lvl, dat_q;
    logic                  chan, have_l, valid, overrun, commit;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] sr, hold, left_data, right_data, word;

    // A slot cut short by LRCK is left-justified so the missing LSBs read as zero.
    always_comb begin
        commit = state == SHIFT && (lr_tr || (rise && cnt == CW'(DATA_WIDTH - 1)));
        word = lr_tr ? sr << (CW'(DATA_WIDTH) - cnt) : {sr[DATA_WIDTH-2:0], dat_q};
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= IDLE;
            bclk_s     <= '0;
            lrck_s     <= '0;
            dat_s      <= '0;
            bclk_d     <= 1'b0;
            lrck_d     <= 1'b0;
            rise       <= 1'b0;
            lr_tr      <= 1'b0;
            lr_lvl     <= 1'b0;
            dat_q      <= 1'b0;
            chan       <= 1'b0;
            have_l     <= 1'b0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            cnt        <= '0;
            sr         <= '0;
            hold       <= '0;
            left_data  <= '0;
            right_data <= '0;
        end else begin
            bclk_s <= {bclk_s[0], bus.AUD_BCLK};
            lrck_s <= {lrck_s[0], bus.AUD_ADCLRCK};
            dat_s  <= {dat_s[0], bus.AUD_ADCDAT};
            bclk_d <= bclk_s[1];
            lrck_d <= lrck_s[1];
            rise   <= bclk_s[1] & ~bclk_d;
            lr_tr  <= lrck_s[1] ^ lrck_d;
            lr_lvl <= lrck_s[1];
            dat_q  <= dat_s[1];
            // An LRCK transition always restarts the one-bit I2S delay for the new channel.
            unique case (state)
                IDLE: begin
                    if (lr_tr) begin
                        state <= SKIP;
                        chan  <= lr_lvl;
                    end
                end
                SKIP: begin
                    if (lr_tr) begin
                        chan <= lr_lvl;
                    end else if (rise) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        sr    <= '0;
                    end
                end
                SHIFT: begin
                    if (lr_tr) begin
                        state <= SKIP;
                        chan  <= lr_lvl;
                    end else if (rise) begin
                        sr    <= {sr[DATA_WIDTH-2:0], dat_q};
                        cnt   <= cnt + CW'(1);
                        state <= cnt == CW'(DATA_WIDTH - 1) ? WAIT : SHIFT;
                    end
                end
                WAIT: begin
                    if (lr_tr) begin
                        state <= SKIP;
                        chan  <= lr_lvl;
                    end
                end
            endcase
            if (commit && !chan) begin
                hold   <= word;
                have_l <= 1'b1;
            end
            if (commit && chan)
                have_l <= 1'b0;
            // A right word only forms a pair when a left word is waiting for it.
            if (commit && chan && have_l) begin
                left_data  <= hold;
                right_data <= word;
                valid      <= 1'b1;
                if (valid && !bus.SAMPLE_READY)
                    overrun <= 1'b1;
            end else if (valid && bus.SAMPLE_READY) begin
                valid <= 1'b0;
            end
        end
    end

    assign bus.LEFT_DATA    = left_data;
    assign bus.RIGHT_DATA   = right_data;
    assign bus.SAMPLE_VALID = valid;
    assign bus.OVERRUN      = overrun;
endmodule

// File: tb/tb_audio_i2s_rx.sv
// tb_audio_i2s_rx: directed I2S frames into 16- and 24-bit receivers sharing one codec bus.
module tb_audio_i2s_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bclk = 1'b0;
    logic lrck = 1'b1;
    logic dat = 1'b0;
    logic ready = 1'b1;
    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    audio_i2s_rx_if #(.DATA_WIDTH(16)) b16 ();
    audio_i2s_rx_if #(.DATA_WIDTH(24)) b24 ();

    assign b16.AUD_BCLK     = bclk;
    assign b16.AUD_ADCLRCK  = lrck;
    assign b16.AUD_ADCDAT   = dat;
    assign b16.SAMPLE_READY = ready;
    assign b24.AUD_BCLK     = bclk;
    assign b24.AUD_ADCLRCK  = lrck;
    assign b24.AUD_ADCDAT   = dat;
    assign b24.SAMPLE_READY = ready;

    audio_i2s_rx #(.DATA_WIDTH(16)) dut16 (.CLOCK(clk), .RESET(rst), .bus(b16.slave));
    audio_i2s_rx #(.DATA_WIDTH(24)) dut24 (.CLOCK(clk), .RESET(rst), .bus(b24.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // BCLK = CLOCK/16; data and LRCK change on the falling edge.
    task automatic low(input logic b);
        bclk = 1'b0;
        dat  = b;
        tick(8);
    endtask

    task automatic send_bit(input logic b);
        low(b);
        bclk = 1'b1;
        tick(8);
    endtask

    task automatic half(input logic lr, input logic [31:0] w, input int msb, input int n, input int pad);
        lrck = lr;
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(w[msb-i]);
        repeat (pad) send_bit(1'b0);
    endtask

    // Raises BCLK for the final bit and returns 3 CLOCK cycles after that edge.
    task automatic lsb_rise(input logic b);
        low(b);
        bclk = 1'b1;
        tick(3);
    endtask

    initial begin
        tick(4);
        rst = 1'b0;
        tick(2);
        chk("rst_valid16", 32'(b16.SAMPLE_VALID), 32'd0);
        chk("rst_left16", 32'(b16.LEFT_DATA), 32'h0);
        chk("rst_right16", 32'(b16.RIGHT_DATA), 32'h0);
        chk("rst_overrun16", 32'(b16.OVERRUN), 32'd0);
        chk("rst_valid24", 32'(b24.SAMPLE_VALID), 32'd0);

        // Basic pair with latency measured from the right LSB edge.
        ready = 1'b1;
        half(1'b0, 32'h8001, 15, 16, 15);
        half(1'b1, 32'h7FFE, 15, 15, 0);
        lsb_rise(1'b0);
        chk("lat3_valid", 32'(b16.SAMPLE_VALID), 32'd0);
        tick(1);
        chk("lat4_valid", 32'(b16.SAMPLE_VALID), 32'd1);
        chk("basic_left", 32'(b16.LEFT_DATA), 32'h8001);
        chk("basic_right", 32'(b16.RIGHT_DATA), 32'h7FFE);
        tick(1);
        chk("basic_valid_drop", 32'(b16.SAMPLE_VALID), 32'd0);
        tick(3);
        repeat (15) send_bit(1'b0);
        chk("w24_basic_left", 32'(b24.LEFT_DATA), 32'h800100);
        chk("w24_basic_right", 32'(b24.RIGHT_DATA), 32'h7FFE00);

        // 24-bit words in 32-bit slots.
        half(1'b0, 32'hA5A5A5, 23, 24, 7);
        half(1'b1, 32'h123456, 23, 24, 7);
        chk("w24_left", 32'(b24.LEFT_DATA), 32'hA5A5A5);
        chk("w24_right", 32'(b24.RIGHT_DATA), 32'h123456);
        chk("w16_trunc_left", 32'(b16.LEFT_DATA), 32'hA5A5);
        chk("w16_trunc_right", 32'(b16.RIGHT_DATA), 32'h1234);

        // New pair lands in the same cycle READY accepts the old one.
        ready = 1'b0;
        half(1'b0, 32'h0011, 15, 16, 15);
        half(1'b1, 32'h0022, 15, 16, 15);
        chk("hold_valid", 32'(b16.SAMPLE_VALID), 32'd1);
        chk("hold_right", 32'(b16.RIGHT_DATA), 32'h0022);
        half(1'b0, 32'h0033, 15, 16, 15);
        half(1'b1, 32'h0044, 15, 15, 0);
        lsb_rise(1'b0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk("same_left", 32'(b16.LEFT_DATA), 32'h0033);
        chk("same_right", 32'(b16.RIGHT_DATA), 32'h0044);
        chk("same_valid", 32'(b16.SAMPLE_VALID), 32'd1);
        chk("same_overrun", 32'(b16.OVERRUN), 32'd0);
        tick(1);
        chk("same_valid_kept", 32'(b16.SAMPLE_VALID), 32'd1);
        ready = 1'b1;
        tick(1);
        chk("same_valid_drain", 32'(b16.SAMPLE_VALID), 32'd0);
        tick(2);
        repeat (15) send_bit(1'b0);

        // Two unaccepted pairs: second overwrites and flags overrun.
        ready = 1'b0;
        half(1'b0, 32'h0001, 15, 16, 15);
        half(1'b1, 32'h0002, 15, 16, 15);
        half(1'b0, 32'h0003, 15, 16, 15);
        half(1'b1, 32'h0004, 15, 16, 15);
        chk("ovr_left", 32'(b16.LEFT_DATA), 32'h0003);
        chk("ovr_right", 32'(b16.RIGHT_DATA), 32'h0004);
        chk("ovr_valid", 32'(b16.SAMPLE_VALID), 32'd1);
        chk("ovr_flag", 32'(b16.OVERRUN), 32'd1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
        chk("ovr_valid_drain", 32'(b16.SAMPLE_VALID), 32'd0);
        chk("ovr_sticky", 32'(b16.OVERRUN), 32'd1);

        // Short 16-bit left slot into the 24-bit receiver.
        ready = 1'b1;
        half(1'b0, 32'hFFFF, 15, 16, 0);
        half(1'b1, 32'h654321, 23, 24, 7);
        chk("short_left24", 32'(b24.LEFT_DATA), 32'hFFFF00);
        chk("short_right24", 32'(b24.RIGHT_DATA), 32'h654321);
        chk("ovr_sticky2", 32'(b16.OVERRUN), 32'd1);

        // Reset during the 10th bit of a right slot.
        half(1'b0, 32'hAAAA, 15, 16, 15);
        lrck = 1'b1;
        send_bit(1'b0);
        repeat (9) send_bit(1'b1);
        bclk = 1'b0;
        dat  = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2);
        chk("mid_rst_left", 32'(b16.LEFT_DATA), 32'h0);
        chk("mid_rst_right", 32'(b16.RIGHT_DATA), 32'h0);
        chk("mid_rst_valid", 32'(b16.SAMPLE_VALID), 32'd0);
        chk("mid_rst_overrun", 32'(b16.OVERRUN), 32'd0);
        chk("mid_rst_overrun24", 32'(b24.OVERRUN), 32'd0);
        rst = 1'b0;
        tick(4);
        bclk = 1'b1;
        tick(8);
        repeat (21) send_bit(1'b1);
        chk("post_rst_no_pair", 32'(b16.SAMPLE_VALID), 32'd0);
        ready = 1'b0;
        half(1'b0, 32'h1357, 15, 16, 15);
        half(1'b1, 32'h2468, 15, 15, 0);
        chk("post_rst_wait", 32'(b16.SAMPLE_VALID), 32'd0);
        lsb_rise(1'b0);
        tick(1);
        chk("post_rst_valid", 32'(b16.SAMPLE_VALID), 32'd1);
        chk("post_rst_left", 32'(b16.LEFT_DATA), 32'h1357);
        chk("post_rst_right", 32'(b16.RIGHT_DATA), 32'h2468);
        tick(4);
        repeat (15) send_bit(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
